rv32i_ctrl_fsm: RTL and testbench

Multi-cycle RV32I control sequencer, successor to the single-cycle R-type decoder. Steps each instruction through fetch/decode/execute/memory/write-back phases and covers all RV32I opcode classes, not just R-type. Handshakes with instruction and data memory, and emits single-cycle write enables in place of gated register and memory clocks. Sits between the instruction register and the datapath (ALU, register file, PC, data memory).

---
 rtl/rv32i_ctrl_fsm.sv | 184 ++++++++++++++++++
 tb/tb_rv32i_ctrl_fsm.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes.
// Define ILLEGAL_TRAP_EN to send unrecognised opcodes to a terminal TRAP state; otherwise they retire as NOPs.
module rv32i_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      insn,
    output logic             fetch_req,
    input  logic             fetch_ack,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             ir_we,
    output logic             sub_sra,
    output logic             addr_sel,
    output logic             pc_alu_sel,
    output logic             pc_next_sel,
    output logic             rd_we,
    output logic             pc_we,
    output logic [CNT_W-1:0] retired,
    output logic             illegal,
    output logic [2:0]       state
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_OPI, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_NOP
    } cls_t;

    state_t           state_q;
    cls_t             cls_q;
    cls_t             cls_d;
    logic [6:0]       op_q;
    logic [2:0]       f3_q;
    logic             b30_q;
    logic             fetch_req_q, mem_req_q, mem_we_q;
    logic             sub_sra_q, addr_sel_q, pc_alu_sel_q, pc_next_sel_q;
    logic             rd_we_q, wb_pc_we_q;
    logic [CNT_W-1:0] retired_q;
    logic             ir_load, mem_done;
    logic             unused_insn;

    assign unused_insn = ^{insn[31], insn[29:15], insn[11:7]};

    always_comb begin
        cls_d = C_NOP;
        case (op_q)
            7'b0110011: cls_d = C_R;
            7'b0010011: cls_d = C_OPI;
            7'b0000011: cls_d = C_LOAD;
            7'b0100011: cls_d = C_STORE;
            7'b1100011: cls_d = C_BRANCH;
            7'b1101111: cls_d = C_JAL;
            7'b1100111: cls_d = C_JALR;
            7'b0110111: cls_d = C_LUI;
            7'b0010111: cls_d = C_AUIPC;
            default:    cls_d = C_NOP;
        endcase
    end

    // Handshake-driven pulses are masked by reset so an aborted access never retires.
    assign ir_load  = fetch_req_q & fetch_ack & ~reset;
    assign mem_done = mem_req_q & mem_ready & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            cls_q         <= C_NOP;
            op_q          <= 7'd0;
            f3_q          <= 3'd0;
            b30_q         <= 1'b0;
            fetch_req_q   <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            sub_sra_q     <= 1'b0;
            addr_sel_q    <= 1'b0;
            pc_alu_sel_q  <= 1'b0;
            pc_next_sel_q <= 1'b0;
            rd_we_q       <= 1'b0;
            wb_pc_we_q    <= 1'b0;
            retired_q     <= '0;
        end else begin
            rd_we_q    <= 1'b0;
            wb_pc_we_q <= 1'b0;
            if (pc_we) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            case (state_q)
                S_FETCH: begin
                    fetch_req_q <= 1'b1;
                    if (ir_load) begin
                        op_q        <= insn[6:0];
                        f3_q        <= insn[14:12];
                        b30_q       <= insn[30];
                        fetch_req_q <= 1'b0;
                        state_q     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    cls_q <= cls_d;
`ifdef ILLEGAL_TRAP_EN
                    if (cls_d == C_NOP) begin
                        state_q <= S_TRAP;
                    end else
`endif
                    begin
                        state_q       <= S_EXEC;
                        sub_sra_q     <= (cls_d == C_R) ? b30_q :
                                         ((cls_d == C_OPI) && (f3_q == 3'b101)) ? b30_q : 1'b0;
                        addr_sel_q    <= (cls_d == C_LOAD) || (cls_d == C_STORE);
                        pc_alu_sel_q  <= (cls_d == C_AUIPC) || (cls_d == C_JAL) || (cls_d == C_BRANCH);
                        pc_next_sel_q <= (cls_d == C_JAL) || (cls_d == C_JALR);
                    end
                end
                S_EXEC: begin
                    if ((cls_q == C_LOAD) || (cls_q == C_STORE)) begin
                        state_q   <= S_MEM;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= (cls_q == C_STORE);
                    end else begin
                        state_q    <= S_WB;
                        rd_we_q    <= (cls_q != C_BRANCH) && (cls_q != C_NOP);
                        wb_pc_we_q <= 1'b1;
                        if (cls_q == C_BRANCH) pc_next_sel_q <= branch_taken;
                    end
                end
                S_MEM: begin
                    if (mem_done) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (cls_q == C_LOAD) begin
                            state_q    <= S_WB;
                            rd_we_q    <= 1'b1;
                            wb_pc_we_q <= 1'b1;
                        end else begin
                            state_q       <= S_FETCH;
                            fetch_req_q   <= 1'b1;
                            sub_sra_q     <= 1'b0;
                            addr_sel_q    <= 1'b0;
                            pc_alu_sel_q  <= 1'b0;
                            pc_next_sel_q <= 1'b0;
                        end
                    end
                end
                S_WB: begin
                    state_q       <= S_FETCH;
                    fetch_req_q   <= 1'b1;
                    sub_sra_q     <= 1'b0;
                    addr_sel_q    <= 1'b0;
                    pc_alu_sel_q  <= 1'b0;
                    pc_next_sel_q <= 1'b0;
                end
                S_TRAP: state_q <= S_TRAP;
                default: state_q <= S_FETCH;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

    assign fetch_req   = fetch_req_q;
    assign ir_we       = ir_load;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign sub_sra     = sub_sra_q;
    assign addr_sel    = addr_sel_q;
    assign pc_alu_sel  = pc_alu_sel_q;
    assign pc_next_sel = pc_next_sel_q;
    assign rd_we       = rd_we_q;
    assign pc_we       = wb_pc_we_q | (mem_done & mem_we_q);
    assign retired     = retired_q;
    assign state       = state_q;
endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Bench for rv32i_ctrl_fsm: per-cycle timeline predicted from phase lengths, checked against the DUT.
module tb_rv32i_ctrl_fsm;
    localparam int CW = 4;
    localparam int K_R = 0, K_OPI = 1, K_LD = 2, K_ST = 3, K_BR = 4,
                   K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_T = 5;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_BUILD = 1'b1;
`else
    localparam bit TRAP_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   insn = 32'd0;
    logic          fetch_ack = 1'b0, mem_ready = 1'b0, branch_taken = 1'b0;
    logic          fetch_req, mem_req, mem_we, ir_we, sub_sra, addr_sel;
    logic          pc_alu_sel, pc_next_sel, rd_we, pc_we, illegal;
    logic [CW-1:0] retired;
    logic [2:0]    state;

    int n_vec = 0;
    int n_bad = 0;
    int ret_exp = 0;

    rv32i_ctrl_fsm #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .insn(insn),
        .fetch_req(fetch_req), .fetch_ack(fetch_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .ir_we(ir_we), .sub_sra(sub_sra),
        .addr_sel(addr_sel), .pc_alu_sel(pc_alu_sel), .pc_next_sel(pc_next_sel),
        .rd_we(rd_we), .pc_we(pc_we), .retired(retired), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'h33: return K_R;
            7'h13: return K_OPI;
            7'h03: return K_LD;
            7'h23: return K_ST;
            7'h63: return K_BR;
            7'h6F: return K_JAL;
            7'h67: return K_JALR;
            7'h37: return K_LUI;
            7'h17: return K_AUIPC;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [13:0] out_vec();
        return {state, fetch_req, ir_we, mem_req, mem_we, rd_we, pc_we, illegal,
                sub_sra, addr_sel, pc_alu_sel, pc_next_sel};
    endfunction

    // One instruction: fw fetch wait cycles, mw memory wait cycles, bt branch outcome.
    // abort_at >= 0 asserts reset in that cycle with mem_ready high and stops there.
    task automatic run_insn(input logic [31:0] ins, input int fw, input int mw,
                            input logic bt, input int abort_at);
        int cls, total, ph, mem_end;
        bit ld, st, br, ill, trap, ab;
        logic [2:0] f3;
        logic       b30, e_sub, e_as, e_pa, e_pn, e_rd, e_pc, act;
        logic [13:0] exp;
        cls  = cls_of(ins[6:0]);
        f3   = ins[14:12];
        b30  = ins[30];
        ld   = (cls == K_LD);
        st   = (cls == K_ST);
        br   = (cls == K_BR);
        ill  = (cls == K_ILL);
        trap = TRAP_BUILD && ill;
        mem_end = fw + 3 + mw;
        if (trap)    total = fw + 22;
        else if (ld) total = fw + 5 + mw;
        else if (st) total = fw + 4 + mw;
        else         total = fw + 4;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            ab = (c == abort_at);
            if (c <= fw)                         ph = P_F;
            else if (c == fw + 1)                ph = P_D;
            else if (trap)                       ph = P_T;
            else if (c == fw + 2)                ph = P_E;
            else if ((ld || st) && c <= mem_end) ph = P_M;
            else                                 ph = P_W;
            insn         = (ph == P_F) ? ins : $urandom;
            fetch_ack    = (ph == P_F) ? (c == fw) : 1'($urandom);
            mem_ready    = ab ? 1'b1 : (ph == P_M) ? (c == mem_end) : 1'($urandom);
            branch_taken = (ph == P_E) ? bt : 1'($urandom);
            reset        = ab;
            #1;
            act  = (ph == P_E) || (ph == P_M) || (ph == P_W);
            e_sub = act && ((cls == K_R) ? b30 : ((cls == K_OPI) && (f3 == 3'b101)) ? b30 : 1'b0);
            e_as = act && (ld || st);
            e_pa = act && (br || cls == K_JAL || cls == K_AUIPC);
            e_pn = act && (cls == K_JAL || cls == K_JALR || (br && ph == P_W && bt));
            e_rd = (ph == P_W) && !(st || br || ill);
            e_pc = !ab && ((ph == P_W) || (st && ph == P_M && c == mem_end));
            exp = {3'(ph), ph == P_F, !ab && ph == P_F && c == fw, ph == P_M, ph == P_M && st,
                   e_rd, e_pc, ph == P_T, e_sub, e_as, e_pa, e_pn};
            chk($sformatf("outs_%h_c%0d", ins, c), 32'(out_vec()), 32'(exp));
            chk($sformatf("retired_%h_c%0d", ins, c), 32'(retired), 32'(ret_exp));
            if (e_pc) ret_exp = (ret_exp + 1) % (1 << CW);
            if (ab) break;
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        fetch_ack = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            chk("reset_outs", 32'(out_vec()), 32'd0);
            chk("reset_retired", 32'(retired), 32'd0);
        end
        ret_exp = 0;
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0]  ops [10];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0B};

        repeat (2) @(posedge clk);
        do_reset(2);

        run_insn(32'h00F100B3, 0, 0, 1'b0, -1);  // add
        run_insn(32'h402A00B3, 1, 0, 1'b0, -1);  // sub
        run_insn(32'h00012083, 0, 3, 1'b0, -1);  // lw
        run_insn(32'h00112023, 0, 0, 1'b0, -1);  // sw
        run_insn(32'h00000063, 0, 0, 1'b1, -1);  // beq taken
        run_insn(32'h00000063, 2, 0, 1'b0, -1);  // beq not taken
        run_insn(32'h40115093, 0, 0, 1'b0, -1);  // srai
        run_insn(32'h40010093, 0, 0, 1'b0, -1);  // addi with bit30 set
        run_insn(32'h0080006F, 0, 0, 1'b0, -1);  // jal
        run_insn(32'h00008067, 0, 0, 1'b1, -1);  // jalr
        run_insn(32'h123450B7, 0, 0, 1'b0, -1);  // lui
        run_insn(32'h00001097, 0, 0, 1'b0, -1);  // auipc
        run_insn(32'h00112023, 1, 2, 1'b0, -1);  // sw with waits

        run_insn(32'hFFFFFFFF, 0, 0, 1'b0, -1);
        if (TRAP_BUILD) do_reset(1);
        run_insn(32'h00F100B3, 0, 0, 1'b0, -1);

        run_insn(32'h00112023, 0, 5, 1'b0, 4);   // reset lands mid-MEM
        @(negedge clk);
        #1;
        chk("abort_outs", 32'(out_vec()), 32'd0);
        chk("abort_retired", 32'(retired), 32'd0);
        ret_exp = 0;
        reset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            r[6:0] = ops[TRAP_BUILD ? $urandom_range(0, 8) : $urandom_range(0, 9)];
            run_insn(r, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
